// File: rtl/fb_arbiter.sv
// Round-robin arbiter sharing one burst memory port between a camera write
// stream and a VGA read stream, each with its own wrapping frame address.
module fb_arbiter #(
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 307200,
  parameter int ADDR_W      = 19
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_req,
  input  logic              wr_frame_start,
  input  logic              rd_req,
  input  logic              rd_frame_start,
  output logic              mem_cmd_vld,
  input  logic              mem_cmd_rdy,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  input  logic              mem_wdata_rdy,
  input  logic              mem_rdata_vld,
  output logic              wr_data_en,
  output logic              rd_data_en,
  output logic              busy
);

  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] LAST_BURST = ADDR_W'(FRAME_WORDS - BURST_LEN);
  localparam logic [BW-1:0]     LAST_BEAT  = BW'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA} state_t;

  state_t            state_q, state_d;
  logic              last_wr_q, last_wr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              wr_pend_q, wr_pend_d;
  logic              rd_pend_q, rd_pend_d;
  logic              wr_burst, rd_burst;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_BURST) ? '0 : a + BURST_STEP;
  endfunction

  assign wr_burst = (state_q == WR_CMD) || (state_q == WR_DATA);
  assign rd_burst = (state_q == RD_CMD) || (state_q == RD_DATA);
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    last_wr_d    = last_wr_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    beat_d       = beat_q;
    wr_pend_d    = wr_pend_q;
    rd_pend_d    = rd_pend_q;
    mem_cmd_vld  = 1'b0;
    mem_cmd_we   = 1'b0;
    mem_cmd_addr = '0;
    wr_data_en   = 1'b0;
    rd_data_en   = 1'b0;

    // A frame start during an own-direction burst is deferred so the command
    // address stays stable; otherwise the address is cleared right away.
    if (wr_frame_start) begin
      if (wr_burst) wr_pend_d = 1'b1;
      else          wr_addr_d = '0;
    end
    if (rd_frame_start) begin
      if (rd_burst) rd_pend_d = 1'b1;
      else          rd_addr_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (wr_req && (!rd_req || !last_wr_q)) begin
          state_d   = WR_CMD;
          last_wr_d = 1'b1;
        end else if (rd_req) begin
          state_d   = RD_CMD;
          last_wr_d = 1'b0;
        end
      end
      WR_CMD: begin
        mem_cmd_vld  = 1'b1;
        mem_cmd_we   = 1'b1;
        mem_cmd_addr = wr_addr_q;
        if (mem_cmd_rdy) begin
          state_d = WR_DATA;
          beat_d  = '0;
        end
      end
      WR_DATA: begin
        wr_data_en = mem_wdata_rdy;
        if (mem_wdata_rdy) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == LAST_BEAT) begin
            state_d   = IDLE;
            wr_addr_d = (wr_pend_q || wr_frame_start) ? '0 : next_addr(wr_addr_q);
            wr_pend_d = 1'b0;
          end
        end
      end
      RD_CMD: begin
        mem_cmd_vld  = 1'b1;
        mem_cmd_addr = rd_addr_q;
        if (mem_cmd_rdy) begin
          state_d = RD_DATA;
          beat_d  = '0;
        end
      end
      RD_DATA: begin
        rd_data_en = mem_rdata_vld;
        if (mem_rdata_vld) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == LAST_BEAT) begin
            state_d   = IDLE;
            rd_addr_d = (rd_pend_q || rd_frame_start) ? '0 : next_addr(rd_addr_q);
            rd_pend_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_wr resets high so the first tie goes to the read side.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      beat_q    <= '0;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      beat_q    <= beat_d;
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Random-stimulus bench for fb_arbiter with a burst-level reference model.
module tb_fb_arbiter;
  localparam int BL = 8;
  localparam int FW = 128;
  localparam int AW = 19;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          wr_req = 1'b0, rd_req = 1'b0;
  logic          wr_frame_start = 1'b0, rd_frame_start = 1'b0;
  logic          mem_cmd_rdy = 1'b0, mem_wdata_rdy = 1'b0, mem_rdata_vld = 1'b0;
  logic          mem_cmd_vld, mem_cmd_we, wr_data_en, rd_data_en, busy;
  logic [AW-1:0] mem_cmd_addr;

  fb_arbiter #(.BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_W(AW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .wr_req(wr_req), .wr_frame_start(wr_frame_start),
    .rd_req(rd_req), .rd_frame_start(rd_frame_start),
    .mem_cmd_vld(mem_cmd_vld), .mem_cmd_rdy(mem_cmd_rdy),
    .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
    .mem_wdata_rdy(mem_wdata_rdy), .mem_rdata_vld(mem_rdata_vld),
    .wr_data_en(wr_data_en), .rd_data_en(rd_data_en), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Burst-level model: phase 0 = between bursts, 1 = command offered, 2 = data.
  // Index 1 = write stream, 0 = read stream.
  int m_phase;
  bit m_dir;
  bit m_last_wr;
  int m_left;
  int m_cmd_addr;
  int m_addr[2];
  bit m_restart[2];
  int n_cmds = 0;
  int n_wraps = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase      = 0;
    m_last_wr    = 1'b1;
    m_left       = 0;
    m_addr[0]    = 0;
    m_addr[1]    = 0;
    m_restart[0] = 1'b0;
    m_restart[1] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(tag, 32'({mem_cmd_vld, mem_cmd_we, mem_cmd_addr, wr_data_en, rd_data_en, busy}), 32'd0);
  endtask

  task automatic check_and_step();
    bit beat;
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("cmd_vld", 32'(mem_cmd_vld), 32'(m_phase == 1));
    if (m_phase == 1) begin
      chk("cmd_we", 32'(mem_cmd_we), 32'(m_dir));
      chk("cmd_addr", 32'(mem_cmd_addr), 32'(m_cmd_addr));
    end
    chk("wr_data_en", 32'(wr_data_en), 32'(m_phase == 2 && m_dir && mem_wdata_rdy));
    chk("rd_data_en", 32'(rd_data_en), 32'(m_phase == 2 && !m_dir && mem_rdata_vld));

    // A frame start seen at any point since the last command of that stream
    // makes its next command start at address 0.
    if (wr_frame_start) m_restart[1] = 1'b1;
    if (rd_frame_start) m_restart[0] = 1'b1;

    case (m_phase)
      0: begin
        if (wr_req || rd_req) begin
          m_dir      = (wr_req && rd_req) ? !m_last_wr : wr_req;
          m_last_wr  = m_dir;
          m_cmd_addr = m_restart[m_dir] ? 0 : m_addr[m_dir];
          m_addr[m_dir]    = m_cmd_addr;
          m_restart[m_dir] = 1'b0;
          m_phase    = 1;
          n_cmds++;
        end
      end
      1: begin
        if (mem_cmd_rdy) begin
          m_phase = 2;
          m_left  = BL;
        end
      end
      default: begin
        beat = m_dir ? mem_wdata_rdy : mem_rdata_vld;
        if (beat) m_left--;
        if (m_left == 0) begin
          m_phase = 0;
          m_addr[m_dir] = (m_addr[m_dir] + BL) % FW;
          if (m_addr[m_dir] == 0) n_wraps++;
        end
      end
    endcase
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    check_reset_outputs("reset_outputs");
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_reset_outputs("post_reset_idle");
    @(posedge sys_clk);
    #1;

    for (int cyc = 0; cyc < 8000; cyc++) begin
      wr_req         = ($urandom_range(0, 99) < 60);
      rd_req         = ($urandom_range(0, 99) < 60);
      mem_cmd_rdy    = ($urandom_range(0, 99) < 50);
      mem_wdata_rdy  = ($urandom_range(0, 99) < 70);
      mem_rdata_vld  = ($urandom_range(0, 99) < 60);
      wr_frame_start = (cyc >= 2500) && ($urandom_range(0, 99) < 2);
      rd_frame_start = (cyc >= 2500) && ($urandom_range(0, 99) < 2);

      if (cyc > 3000 && $urandom_range(0, 699) == 0) begin
        #2 sys_rst = 1'b1;
        #1 check_reset_outputs("async_reset_outputs");
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        model_reset();
        continue;
      end

      @(negedge sys_clk);
      check_and_step();
      @(posedge sys_clk);
      #1;
    end

    chk("commands_issued", 32'(n_cmds > 200), 32'd1);
    chk("address_wraps", 32'(n_wraps > 4), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 8: words per burst; power of two, 2..64.
REQ-002 Parameter FRAME_WORDS, default 307200: words per frame (640x480); integer multiple of BURST_LEN.
REQ-003 Parameter ADDR_W, default 19: width of the word address.
REQ-004 sys_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 sys_rst  in  1  reset, asynchronous, active-high.
REQ-006 wr_req  in  1  level; camera write FIFO holds >= BURST_LEN words.
REQ-007 wr_frame_start  in  1  one-cycle pulse; camera frame begins, write address returns to 0.
REQ-008 rd_req  in  1  level; VGA read FIFO has room for >= BURST_LEN words.
REQ-009 rd_frame_start  in  1  one-cycle pulse (from vsync); read address returns to 0.
REQ-010 mem_cmd_vld  out  1  burst command valid.
REQ-011 mem_cmd_rdy  in  1  memory accepts command.
REQ-012 mem_cmd_we  out  1  1 = write burst, 0 = read burst.
REQ-013 mem_cmd_addr  out  ADDR_W  burst start word address.
REQ-014 mem_wdata_rdy  in  1  memory accepts one write beat this cycle.
REQ-015 mem_rdata_vld  in  1  memory returns one read beat this cycle.
REQ-016 wr_data_en  out  1  pop camera FIFO / write beat taken.
REQ-017 rd_data_en  out  1  push VGA FIFO / read beat present.
REQ-018 busy  out  1  high whenever state is not IDLE.

Function
REQ-019 State machine SHALL have exactly states IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA.
REQ-020 IDLE: no request -> stay; only rd_req -> RD_CMD; only wr_req -> WR_CMD; both -> grant opposite of last_grant (round-robin).
REQ-021 last_grant SHALL update on every entry to WR_CMD or RD_CMD.
REQ-022 WR_CMD/RD_CMD: mem_cmd_vld=1, mem_cmd_we=1/0, mem_cmd_addr=wr_addr/rd_addr, held stable until mem_cmd_rdy=1; then -> WR_DATA/RD_DATA.
REQ-023 WR_DATA: wr_data_en = mem_wdata_rdy (combinational); beat counter increments per beat; after beat BURST_LEN -> IDLE.
REQ-024 RD_DATA: rd_data_en = mem_rdata_vld (combinational); beat counter increments per beat; after beat BURST_LEN -> IDLE.
REQ-025 wr_data_en SHALL be 0 outside WR_DATA; rd_data_en SHALL be 0 outside RD_DATA, regardless of memory inputs.
REQ-026 Requests SHALL be sampled only in IDLE; wr_req/rd_req changes during a burst SHALL NOT abort it.
REQ-027 Minimum of one IDLE cycle between consecutive bursts.
REQ-028 On burst completion, matching address SHALL advance by BURST_LEN; value FRAME_WORDS wraps to 0.
REQ-029 wr_frame_start in IDLE: wr_addr <= 0 next cycle; same for rd_frame_start/rd_addr.
REQ-030 frame_start during a burst of the same direction: set pending flag; command address unchanged; at burst end address <= 0 instead of advancing; flag cleared.
REQ-031 frame_start during a burst of the other direction, or coinciding with IDLE grant: address <= 0 before it is used; the granted command SHALL carry address 0.
REQ-032 frame_start coincident with completing beat: address <= 0 (frame start wins over advance/wrap).
REQ-033 Beat counter width log2(BURST_LEN)+1; cleared on entry to WR_DATA/RD_DATA.

Reset
REQ-034 sys_rst=1 SHALL immediately force: state IDLE, wr_addr=0, rd_addr=0, beat counter 0, pending flags 0, last_grant=write (read wins first tie).
REQ-035 During reset all outputs SHALL be 0: mem_cmd_vld, mem_cmd_we, mem_cmd_addr, wr_data_en, rd_data_en, busy.
REQ-036 Reset asserted mid-burst SHALL abandon the burst; after release the first grant restarts from address 0.

Verification
REQ-037 Reset release, wr_req=rd_req=1 together -> first command read at addr 0, then write at addr 0, then read at addr 8 (BURST_LEN=8).
REQ-038 Only rd_req, mem_cmd_rdy held 0 for 5 cycles -> mem_cmd_vld/addr stable 5 cycles, RD_DATA entered cycle after rdy=1; 8 mem_rdata_vld beats with gaps -> exactly 8 rd_data_en pulses, then busy=0.
REQ-039 38400 consecutive write bursts -> last command addr 307192, next command addr 0.
REQ-040 rd_frame_start at beat 3 of read burst at addr 800 -> burst completes 8 beats, next read command addr 0.
REQ-041 mem_wdata_rdy/mem_rdata_vld toggled in IDLE and opposite-direction states -> wr_data_en/rd_data_en stay 0.
REQ-042 sys_rst pulsed during beat 4 of write at addr 64 -> all outputs 0 asynchronously; next write command addr 0.
